// File: rtl/fpu_wb_sched.sv
// fpu_wb_sched: issue scheduler for the FPU's fixed-latency units.
// It reserves a writeback slot per accepted op so the shared result
// port never sees two results in one cycle.
// Optional build macro: FPU_SCHED_CHECK_EN enables the unit_out_valid
// cross-check and the sticky err flag.
module fpu_wb_sched #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned LAT_SGN = 1,
    parameter int unsigned LAT_MUL = 2,
    parameter int unsigned LAT_ADD = 3,
    parameter int unsigned LAT_DIV = 8,
    parameter int unsigned MAX_LAT = 8,
    localparam int unsigned OW     = $clog2(MAX_LAT + 1)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_unit,
    input  logic [TAG_W-1:0] in_tag,
    output logic             in_ready,
    output logic [3:0]       issue_valid,
    output logic             wb_valid,
    output logic [3:0]       wb_sel,
    output logic [TAG_W-1:0] wb_tag,
    output logic [OW-1:0]    outstanding,
    input  logic [3:0]       unit_out_valid,
    output logic             err
);

    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    typedef struct packed {
        logic             v;
        logic [1:0]       unit;
        logic [TAG_W-1:0] tag;
    } ent_t;

    // tbl_q[k] holds the reservation for the cycle k ahead of the current one.
    ent_t             tbl_q [1:MAX_LAT];
    ent_t             tbl_d [1:MAX_LAT];
    logic             wb_valid_q, wb_valid_d;
    logic [3:0]       wb_sel_q, wb_sel_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [OW-1:0]    outstanding_q, outstanding_d;
    div_state_t       div_state_q, div_state_d;
    logic [OW-1:0]    div_cnt_q, div_cnt_d;
    logic             err_q, err_d;

    logic [OW-1:0]    lat;
    logic             slot_busy;
    logic             div_block;
    logic             xfer;
    logic             is_div;
    ent_t             new_ent;
    ent_t             wb_ent;

    // Acceptance, steering and next-state computation for the whole scheduler.
    always_comb begin
        unique case (in_unit)
            2'd0:    lat = OW'(LAT_SGN);
            2'd1:    lat = OW'(LAT_MUL);
            2'd2:    lat = OW'(LAT_ADD);
            default: lat = OW'(LAT_DIV);
        endcase
        is_div    = (in_unit == 2'd3);
        slot_busy = tbl_q[lat].v;
        // The divider's final busy cycle is the one its result writes back,
        // so a follow-on DIV is allowed then for LAT_DIV spacing.
        div_block = is_div && (div_state_q == DIV_BUSY) && (div_cnt_q != '0);
        in_ready  = !slot_busy && !div_block;
        xfer      = in_valid && in_ready;

        issue_valid = '0;
        if (xfer) begin
            issue_valid[in_unit] = 1'b1;
        end

        new_ent = '{v: 1'b1, unit: in_unit, tag: in_tag};

        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            tbl_d[k] = tbl_q[k+1];
        end
        tbl_d[MAX_LAT] = '0;

        // A latency-1 op bypasses the table and goes straight to the result regs.
        wb_ent = tbl_q[1];
        if (xfer) begin
            if (lat == OW'(1)) begin
                wb_ent = new_ent;
            end else begin
                tbl_d[lat - OW'(1)] = new_ent;
            end
        end

        wb_valid_d = wb_ent.v;
        wb_sel_d   = wb_ent.v ? (4'b0001 << wb_ent.unit) : 4'b0000;
        wb_tag_d   = wb_ent.v ? wb_ent.tag : '0;

        outstanding_d = outstanding_q;
        if (xfer && !wb_valid_q) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!xfer && wb_valid_q) begin
            outstanding_d = outstanding_q - OW'(1);
        end

        div_state_d = div_state_q;
        div_cnt_d   = div_cnt_q;
        if (xfer && is_div) begin
            div_state_d = DIV_BUSY;
            div_cnt_d   = OW'(LAT_DIV - 1);
        end else if (div_state_q == DIV_BUSY) begin
            if (div_cnt_q == '0) begin
                div_state_d = DIV_IDLE;
            end else begin
                div_cnt_d = div_cnt_q - OW'(1);
            end
        end

`ifdef FPU_SCHED_CHECK_EN
        err_d = err_q || (unit_out_valid != wb_sel_q);
`else
        err_d = 1'b0;
`endif
    end

`ifndef FPU_SCHED_CHECK_EN
    logic unused_unit_out_valid;
    assign unused_unit_out_valid = ^unit_out_valid;
`endif

    // All scheduler state, with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                tbl_q[k] <= '0;
            end
            wb_valid_q    <= 1'b0;
            wb_sel_q      <= '0;
            wb_tag_q      <= '0;
            outstanding_q <= '0;
            div_state_q   <= DIV_IDLE;
            div_cnt_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                tbl_q[k] <= tbl_d[k];
            end
            wb_valid_q    <= wb_valid_d;
            wb_sel_q      <= wb_sel_d;
            wb_tag_q      <= wb_tag_d;
            outstanding_q <= outstanding_d;
            div_state_q   <= div_state_d;
            div_cnt_q     <= div_cnt_d;
            err_q         <= err_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_sel      = wb_sel_q;
    assign wb_tag      = wb_tag_q;
    assign outstanding = outstanding_q;
    assign err         = err_q;

endmodule
